// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit: one multiplier bit per cycle over WIDTH cycles,
// followed by a single register-file write-back cycle on port 3.
module mul_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accumulate,
  input  logic [ADDR_WIDTH-1:0] rd_dest,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [WIDTH-1:0]      op_acc,
  output logic                  busy,
  output logic                  done,
  output logic                  we3,
  output logic [ADDR_WIDTH-1:0] wa3,
  output logic [WIDTH-1:0]      wd3,
  output logic                  res_n,
  output logic                  res_z
);

  // Handshake: start is a request that is taken only while busy=0 (IDLE);
  // busy=1 means any start is dropped, there is no queueing.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mplier;
  logic [WIDTH-1:0]      prod;
  logic [ADDR_WIDTH-1:0] dest;
  logic [CW-1:0]         count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CALC;
      S_CALC:  if (count == LAST) state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Fixed WIDTH iterations with no early exit keeps latency data-independent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      dest   <= '0;
      count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            dest   <= rd_dest;
            prod   <= accumulate ? op_acc : '0;
            count  <= '0;
          end
        end
        S_CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign we3   = (state == S_WB);
  assign done  = (state == S_WB);
  assign wa3   = dest;
  assign wd3   = prod;
  assign res_n = prod[WIDTH-1];
  assign res_z = (prod == '0);

endmodule
